// File: rtl/mod8_down_counter_ego1_pkg.sv
// Shared definitions for the EGO1 mod-8 counter board tops (up and down).
// Contents:
//   db_state_e  - debouncer FSM states
//   LED_*       - LED bit positions for the counter state and the borrow/carry flag
//   led_map()   - packs a 3-bit state {y3,y2,y1} and a flag bit onto the 16 LEDs
package mod8_down_counter_ego1_pkg;

  typedef enum logic [1:0] {
    DB_IDLE         = 2'd0,
    DB_WAIT_PRESS   = 2'd1,
    DB_PRESSED      = 2'd2,
    DB_WAIT_RELEASE = 2'd3
  } db_state_e;

  localparam int unsigned LED_Y3     = 0;
  localparam int unsigned LED_Y2     = 1;
  localparam int unsigned LED_Y1     = 2;
  localparam int unsigned LED_BORROW = 3;

  // State MSB (y3) lands on LED 0, so the state appears bit-reversed on led[2:0].
  function automatic logic [15:0] led_map(input logic [2:0] state, input logic flag);
    logic [15:0] led;
    led             = '0;
    led[LED_Y3]     = state[2];
    led[LED_Y2]     = state[1];
    led[LED_Y1]     = state[0];
    led[LED_BORROW] = flag;
    return led;
  endfunction

endpackage

// File: rtl/mod8_down_counter_ego1_btn_debounce.sv
// Push-button conditioner: 2-flop synchroniser followed by a press/release
// debounce FSM. A level must be stable for DEBOUNCE_CYCLES samples before it is
// accepted; each accepted edge produces a single-cycle registered pulse.
// Ports:
//   clk        in   board clock
//   rst        in   synchronous, active-high reset
//   btn        in   raw asynchronous, bouncy button level (released = 0)
//   press_p    out  one-cycle pulse on a debounced press
//   release_p  out  one-cycle pulse on a debounced release
module btn_debounce
  import mod8_down_counter_ego1_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned CNT_W           = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press_p,
  output logic release_p
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q;
  logic             sync2_q;
  db_state_e        state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             press_q;
  logic             release_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= btn;
      sync2_q <= sync1_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= DB_IDLE;
      cnt_q     <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      press_q   <= 1'b0;
      release_q <= 1'b0;
      case (state_q)
        DB_IDLE: begin
          if (sync2_q) begin
            state_q <= DB_WAIT_PRESS;
            cnt_q   <= '0;
          end
        end
        DB_WAIT_PRESS: begin
          if (!sync2_q) begin
            state_q <= DB_IDLE;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= DB_PRESSED;
            press_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        DB_PRESSED: begin
          if (!sync2_q) begin
            state_q <= DB_WAIT_RELEASE;
            cnt_q   <= '0;
          end
        end
        DB_WAIT_RELEASE: begin
          if (sync2_q) begin
            state_q <= DB_PRESSED;
          end else if (cnt_q == CNT_LAST) begin
            state_q   <= DB_IDLE;
            release_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: state_q <= DB_IDLE;
      endcase
    end
  end

  assign press_p   = press_q;
  assign release_p = release_q;

endmodule

// File: rtl/mod8_down_counter_ego1.sv
// EGO1 board top: 3-bit mod-8 down-counter.
// A debounced release of S1 decrements the state (wrapping 0 -> 7 and setting
// borrow); a debounced press of S2 loads the DIP-switch preset and clears
// borrow. Load wins when both pulses coincide.
// Ports:
//   clk        in   100 MHz board clock
//   rst        in   synchronous, active-high reset
//   btn_step   in   S1 button (step on release)
//   btn_load   in   S2 button (load on press)
//   sw_preset  in   load value {y3,y2,y1}
//   led_pin    out  [0]=y3 [1]=y2 [2]=y1 [3]=borrow, [15:4]=0; register-driven
module mod8_down_counter_ego1
  import mod8_down_counter_ego1_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned CNT_W           = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_step,
  input  logic        btn_load,
  input  logic [2:0]  sw_preset,
  output logic [15:0] led_pin
);

  logic       step_release;
  logic       load_press;
  logic       step_press_unused;
  logic       load_release_unused;

  logic [2:0] state_q, state_d;
  logic       borrow_q, borrow_d;

  btn_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_db_step (
    .clk       (clk),
    .rst       (rst),
    .btn       (btn_step),
    .press_p   (step_press_unused),
    .release_p (step_release)
  );

  btn_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_db_load (
    .clk       (clk),
    .rst       (rst),
    .btn       (btn_load),
    .press_p   (load_press),
    .release_p (load_release_unused)
  );

  always_comb begin
    state_d  = state_q;
    borrow_d = borrow_q;
    if (load_press) begin
      state_d  = sw_preset;
      borrow_d = 1'b0;
    end else if (step_release) begin
      state_d  = state_q - 3'd1;
      borrow_d = (state_q == 3'b000);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= '0;
      borrow_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      borrow_q <= borrow_d;
    end
  end

  assign led_pin = led_map(state_q, borrow_q);

endmodule
